// File: rtl/ty_axis_pack4.sv
`timescale 1ns/1ps
// ty_axis_pack4
// Packs a scalar W-bit AXI-stream into LANES-word vector beats. The word at
// in-beat index k lands in m_tdata[W*(LANES-k)-1 -: W], so the first word of
// a beat sits in the most significant lane. A beat closes after the fourth
// word or on s_tlast. Lanes after a short close are zero-filled, and the
// short frame is flagged in a sticky error bit.
//
// Ports:
//   aclk, areset_n          clock, asynchronous active-low reset
//   s_tvalid/s_tdata/s_tlast/s_tready   scalar input stream
//   m_tvalid/m_tdata/m_tlast/m_tready   packed output stream
//   err_short               sticky: a frame ended mid-beat
//   beat_count              output handshakes, wraps modulo 2^CNTW
module ty_axis_pack4 #(
    parameter int W     = 32,
    parameter int LANES = 4,
    parameter int CNTW  = 32
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    input  logic                 s_tvalid,
    input  logic [W-1:0]         s_tdata,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic                 m_tvalid,
    output logic [W*LANES-1:0]   m_tdata,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 err_short,
    output logic [CNTW-1:0]      beat_count
);

    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    logic [1:0]                cnt;
    logic [LANES-2:0][W-1:0]   lanes_q;
    logic [W*LANES-1:0]        obuf;
    logic                      ovld;
    logic                      olast;
    logic [W*LANES-1:0]        beat;
    logic                      accept;
    logic                      close;

    // Non-closing words always have room in the assembly register, so only a
    // closing word (lane 3 or tlast) can be held off by a full output buffer.
    assign s_tready = ((cnt != LAST_LANE) & ~s_tlast) | ~ovld | m_tready;
    assign accept   = s_tvalid & s_tready;
    assign close    = accept & ((cnt == LAST_LANE) | s_tlast);

    assign m_tvalid = ovld;
    assign m_tdata  = obuf;
    assign m_tlast  = olast;

    // Assembled beat: stored lanes, then the current word, then zero padding.
    always_comb begin
        beat = '0;
        case (cnt)
            2'd0:    beat = {s_tdata, {(3*W){1'b0}}};
            2'd1:    beat = {lanes_q[0], s_tdata, {(2*W){1'b0}}};
            2'd2:    beat = {lanes_q[0], lanes_q[1], s_tdata, {W{1'b0}}};
            default: beat = {lanes_q[0], lanes_q[1], lanes_q[2], s_tdata};
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            cnt        <= '0;
            lanes_q    <= '0;
            obuf       <= '0;
            ovld       <= 1'b0;
            olast      <= 1'b0;
            err_short  <= 1'b0;
            beat_count <= '0;
        end else begin
            if (close) begin
                obuf    <= beat;
                olast   <= s_tlast;
                ovld    <= 1'b1;
                cnt     <= '0;
                lanes_q <= '0;
                // A close below lane 3 can only come from tlast.
                if (cnt != LAST_LANE) begin
                    err_short <= 1'b1;
                end
            end else begin
                if (m_tready) begin
                    ovld <= 1'b0;
                end
                if (accept) begin
                    case (cnt)
                        2'd0:    lanes_q[0] <= s_tdata;
                        2'd1:    lanes_q[1] <= s_tdata;
                        2'd2:    lanes_q[2] <= s_tdata;
                        default: ;
                    endcase
                    cnt <= cnt + 2'd1;
                end
            end

            if (ovld & m_tready) begin
                beat_count <= beat_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ty_axis_pack4.sv
`timescale 1ns/1ps
module tb_ty_axis_pack4;

    logic         aclk = 1'b0;
    logic         areset_n = 1'b0;
    logic         s_tvalid = 1'b0;
    logic [31:0]  s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic         m_tvalid;
    logic [127:0] m_tdata;
    logic         m_tlast;
    logic         m_tready = 1'b0;
    logic         err_short;
    logic [31:0]  beat_count;

    always #5 aclk = ~aclk;

    ty_axis_pack4 #(.W(32), .LANES(4), .CNTW(32)) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .err_short  (err_short),
        .beat_count (beat_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: words of the beat being gathered, and beats awaiting
    // delivery stored as {tlast, data}.
    logic [31:0]  wq[$];
    logic [128:0] exp_q[$];
    logic         m_err;
    logic [31:0]  m_cnt;

    // Values seen in the most recent step.
    logic         a_sready, a_mvalid, a_mlast, a_err, last_acc;
    logic [127:0] a_mdata;
    logic [31:0]  a_cnt;
    int           hs_n, last_seen, last_idx, sready_low;

    task automatic model_reset();
        wq.delete();
        exp_q.delete();
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, compare with the
    // model, advance the model, then wait for the rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic mr);
        logic         e_ready;
        logic [127:0] b;
        logic [31:0]  w;
        @(negedge aclk);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = mr;
        #1;
        a_sready = s_tready;
        a_mvalid = m_tvalid;
        a_mdata  = m_tdata;
        a_mlast  = m_tlast;
        a_err    = err_short;
        a_cnt    = beat_count;
        e_ready = (wq.size() < 3 && !l) || exp_q.size() == 0 || mr;
        chk("s_tready", 128'(a_sready), 128'(e_ready));
        chk("m_tvalid", 128'(a_mvalid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_tdata", a_mdata, exp_q[0][127:0]);
            chk("m_tlast", 128'(a_mlast), 128'(exp_q[0][128]));
        end
        chk("err_short", 128'(a_err), 128'(m_err));
        chk("beat_count", 128'(a_cnt), 128'(m_cnt));
        if (!a_sready) sready_low++;
        if (a_mvalid && mr) begin
            hs_n++;
            if (a_mlast) begin
                last_seen++;
                last_idx = hs_n;
            end
        end
        last_acc = v && e_ready;
        if (exp_q.size() != 0 && mr) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (last_acc) begin
            wq.push_back(d);
            if (wq.size() == 4 || l) begin
                if (wq.size() < 4) m_err = 1'b1;
                b = '0;
                for (int k = 0; k < 4; k++) begin
                    w = (k < wq.size()) ? wq[k] : 32'h0;
                    b = {b[95:0], w};
                end
                exp_q.push_back({l, b});
                wq.delete();
            end
        end
        @(posedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        #1;
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tdata", m_tdata, 128'(0));
        chk("rst_m_tlast", 128'(m_tlast), 128'(0));
        chk("rst_err_short", 128'(err_short), 128'(0));
        chk("rst_beat_count", 128'(beat_count), 128'(0));
        chk("rst_s_tready", 128'(s_tready), 128'(1));
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         mr;
        logic         e_sready;
        logic         e_mvalid;
        logic [127:0] e_mdata;
        logic         e_mlast;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [127:0] held;
        int tries;
        model_reset();
        hs_n = 0; last_seen = 0; last_idx = 0; sready_low = 0; last_acc = 1'b0;

        // Basic beat: 0x11..0x44 with tlast on the fourth word.
        tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
        tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
        tbl[3] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1,
                   128'h00000011_00000022_00000033_00000044, 1'b1};
        tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
            chk($sformatf("tbl%0d_s_tready", i), 128'(a_sready), 128'(tbl[i].e_sready));
            chk($sformatf("tbl%0d_m_tvalid", i), 128'(a_mvalid), 128'(tbl[i].e_mvalid));
            if (tbl[i].e_mvalid) begin
                chk($sformatf("tbl%0d_m_tdata", i), a_mdata, tbl[i].e_mdata);
                chk($sformatf("tbl%0d_m_tlast", i), 128'(a_mlast), 128'(tbl[i].e_mlast));
            end
        end
        chk("basic_beat_count", 128'(a_cnt), 128'(1));
        chk("basic_err_short", 128'(a_err), 128'(0));

        // 400 streaming words, tlast on the last.
        do_reset();
        hs_n = 0; last_seen = 0; last_idx = 0; sready_low = 0;
        for (int i = 0; i < 400; i++) step(1'b1, 32'(i + 1), (i == 399), 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stream_s_tready_low", 128'(sready_low), 128'(0));
        chk("stream_beats", 128'(hs_n), 128'(100));
        chk("stream_tlast_count", 128'(last_seen), 128'(1));
        chk("stream_tlast_index", 128'(last_idx), 128'(100));
        chk("stream_beat_count", 128'(a_cnt), 128'(100));

        // Six-word frame: full beat then padded short beat.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
        step(1'b1, 32'd5, 1'b0, 1'b1);
        chk("short_beat0_valid", 128'(a_mvalid), 128'(1));
        chk("short_beat0_data", a_mdata, 128'h00000001_00000002_00000003_00000004);
        chk("short_beat0_last", 128'(a_mlast), 128'(0));
        chk("short_err_before", 128'(a_err), 128'(0));
        step(1'b1, 32'd6, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("short_beat1_data", a_mdata, 128'h00000005_00000006_00000000_00000000);
        chk("short_beat1_last", 128'(a_mlast), 128'(1));
        chk("short_err_after", 128'(a_err), 128'(1));

        // Backpressure: beat0 held, three more words absorbed, eighth stalls.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        held = 128'h00000001_00000002_00000003_00000004;
        for (int i = 5; i <= 7; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            chk($sformatf("bp_word%0d_ready", i), 128'(a_sready), 128'(1));
            chk($sformatf("bp_hold%0d_data", i), a_mdata, held);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'd8, 1'b1, 1'b0);
            chk("bp_word8_stalled", 128'(a_sready), 128'(0));
            chk("bp_word8_hold_data", a_mdata, held);
            chk("bp_word8_hold_valid", 128'(a_mvalid), 128'(1));
        end
        step(1'b1, 32'd8, 1'b1, 1'b1);
        chk("bp_release_ready", 128'(a_sready), 128'(1));
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp_beat1_valid", 128'(a_mvalid), 128'(1));
        chk("bp_beat1_data", a_mdata, 128'h00000005_00000006_00000007_00000008);
        chk("bp_beat1_last", 128'(a_mlast), 128'(1));
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp_beat_count", 128'(a_cnt), 128'(2));

        // Asynchronous reset in the middle of a beat with live output state.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'hE0, 1'b1, 1'b0);
        step(1'b1, 32'hF0, 1'b0, 1'b0);
        step(1'b1, 32'hF1, 1'b0, 1'b0);
        chk("arst_pre_valid", 128'(m_tvalid), 128'(1));
        chk("arst_pre_err", 128'(err_short), 128'(1));
        #2;
        areset_n = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        chk("arst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("arst_m_tlast", 128'(m_tlast), 128'(0));
        chk("arst_m_tdata", m_tdata, 128'(0));
        chk("arst_err_short", 128'(err_short), 128'(0));
        chk("arst_beat_count", 128'(beat_count), 128'(0));
        chk("arst_s_tready", 128'(s_tready), 128'(1));
        @(negedge aclk);
        areset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("arst_fresh_data", a_mdata, 128'h000000C0_000000C1_000000C2_000000C3);

        // beat_count wrap from all-ones.
        do_reset();
        @(negedge aclk);
        force dut.beat_count = 32'hFFFF_FFFF;
        #1;
        release dut.beat_count;
        m_cnt = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_beat_count", 128'(a_cnt), 128'(0));

        // Randomized frames with random gaps and backpressure.
        do_reset();
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 13);
            for (int w = 0; w < len; w++) begin
                logic [31:0] d;
                d = $urandom;
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
                tries = 0;
                do begin
                    step(1'b1, d, (w == len - 1), ($urandom_range(0, 9) < 7));
                    tries++;
                end while (!last_acc && tries < 100);
                if (!last_acc) chk("rand_accept_timeout", 128'(0), 128'(1));
            end
        end
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
